// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the hazard controller and the forwarding unit:
// controller states, NOP encoding, register-index width and forwarding selects.
package hazard_controller_pkg;

  localparam int REG_W = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE    = 2'b00,
    SEL_EXE_MEM = 2'b01,
    SEL_MEM_WB  = 2'b10
  } sel_risk_e;

endpackage

// File: rtl/hazard_controller_hazard_detect.sv
// Combinational load-use comparator: a load in execute whose destination
// is read by the instruction in decode. Shared with the forwarding unit.
module hazard_detect #(
  parameter int REG_W = hazard_controller_pkg::REG_W
) (
  input  logic [REG_W-1:0] Ra_F_Reg,
  input  logic [REG_W-1:0] Rb_F_Reg,
  input  logic             RE_A_F_Reg,
  input  logic             RE_B_F_Reg,
  input  logic [REG_W-1:0] Robj_Reg_Exe,
  input  logic             mem_RE_Reg_Exe,
  output logic             load_use
);

  assign load_use = mem_RE_Reg_Exe &&
                    ((Ra_F_Reg == Robj_Reg_Exe && RE_A_F_Reg) ||
                     (Rb_F_Reg == Robj_Reg_Exe && RE_B_F_Reg));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory waits.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int REG_W        = hazard_controller_pkg::REG_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Ra_F_Reg,
  input  logic [REG_W-1:0] Rb_F_Reg,
  input  logic             RE_A_F_Reg,
  input  logic             RE_B_F_Reg,
  input  logic [REG_W-1:0] Robj_Reg_Exe,
  input  logic             mem_RE_Reg_Exe,
  input  logic             branch_taken_Exe,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             bubble_E,
  output logic             bubble_WB,
  output logic             flush_F,
  output logic             mem_timeout,
  output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt_total,
  output logic [CNT_W-1:0] mem_wait_cnt
`endif
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1)
  begin : g_param_check
    $error("hazard_controller: parameter out of range");
  end

  localparam logic [2:0] FLUSH_LEN   = 3'(FLUSH_CYCLES);
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic [2:0] saved_q, saved_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       set_timeout;
  logic       load_use, mem_miss;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .Ra_F_Reg       (Ra_F_Reg),
    .Rb_F_Reg       (Rb_F_Reg),
    .RE_A_F_Reg     (RE_A_F_Reg),
    .RE_B_F_Reg     (RE_B_F_Reg),
    .Robj_Reg_Exe   (Robj_Reg_Exe),
    .mem_RE_Reg_Exe (mem_RE_Reg_Exe),
    .load_use       (load_use)
  );

  assign mem_miss = mem_req && !mem_ready;
  assign state_o  = state_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    saved_d     = saved_q;
    wait_cnt_d  = wait_cnt_q;
    set_timeout = 1'b0;
    {stall_F, stall_D, stall_E, stall_M, bubble_E, bubble_WB, flush_F} = '0;
    // Strobes are held low throughout reset, even with live pipeline inputs.
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (mem_miss) begin
            {stall_F, stall_D, stall_E, stall_M, bubble_WB} = '1;
            state_d    = MEM_WAIT;
            wait_cnt_d = 8'd1;
            saved_d    = branch_taken_Exe ? FLUSH_LEN : 3'd0;
          end else if (branch_taken_Exe) begin
            flush_F  = 1'b1;
            bubble_E = 1'b1;
            if (FLUSH_LEN > 3'd1) begin
              state_d     = FLUSH;
              flush_cnt_d = FLUSH_LEN - 3'd1;
            end
          end else if (load_use) begin
            stall_F  = 1'b1;
            stall_D  = 1'b1;
            bubble_E = 1'b1;
          end
        end
        FLUSH: begin
          if (mem_miss) begin
            {stall_F, stall_D, stall_E, stall_M} = '1;
            state_d     = MEM_WAIT;
            wait_cnt_d  = 8'd1;
            saved_d     = flush_cnt_q;
            flush_cnt_d = 3'd0;
          end else begin
            flush_F = 1'b1;
            if (flush_cnt_q <= 3'd1) begin
              state_d     = RUN;
              flush_cnt_d = 3'd0;
            end else begin
              flush_cnt_d = flush_cnt_q - 3'd1;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_miss && wait_cnt_q < TIMEOUT_CNT) begin
            {stall_F, stall_D, stall_E, stall_M, bubble_WB} = '1;
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
          end else begin
            set_timeout = mem_miss;
            wait_cnt_d  = 8'd0;
            saved_d     = 3'd0;
            if (saved_q != 3'd0) begin
              state_d     = FLUSH;
              flush_cnt_d = saved_q;
            end else begin
              state_d = RUN;
            end
          end
        end
        default: begin
          state_d     = RUN;
          flush_cnt_d = 3'd0;
          saved_d     = 3'd0;
          wait_cnt_d  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      saved_q     <= 3'd0;
      wait_cnt_q  <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      saved_q     <= saved_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_timeout <= mem_timeout | set_timeout;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Only the load-use case raises stall_D without stall_E.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_stall_cnt  <= '0;
      flush_cnt_total <= '0;
      mem_wait_cnt    <= '0;
    end else begin
      if (stall_D && !stall_E && load_stall_cnt != '1)  load_stall_cnt  <= load_stall_cnt + 1'b1;
      if (flush_F && flush_cnt_total != '1)             flush_cnt_total <= flush_cnt_total + 1'b1;
      if (stall_M && mem_wait_cnt != '1)                mem_wait_cnt    <= mem_wait_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random
// traffic against a cycle-level behavioural model of the hazard rules.
module tb_hazard_controller;

  localparam int REG_W = 4;
  localparam int FC    = 2;
  localparam int MT    = 15;
  localparam int CNT_W = 16;

  localparam logic [6:0] E_STALL_WB = 7'b1111010;
  localparam logic [6:0] E_STALL    = 7'b1111000;
  localparam logic [6:0] E_FLUSH    = 7'b0000001;
  localparam logic [6:0] E_BRANCH   = 7'b0000101;
  localparam logic [6:0] E_LOADUSE  = 7'b1100100;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] Ra_F_Reg, Rb_F_Reg, Robj_Reg_Exe;
  logic RE_A_F_Reg, RE_B_F_Reg, mem_RE_Reg_Exe, branch_taken_Exe, mem_req, mem_ready;
  logic stall_F, stall_D, stall_E, stall_M, bubble_E, bubble_WB, flush_F, mem_timeout;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] load_stall_cnt, flush_cnt_total, mem_wait_cnt;
`endif

  hazard_controller #(.REG_W(REG_W), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Ra_F_Reg(Ra_F_Reg), .Rb_F_Reg(Rb_F_Reg), .RE_A_F_Reg(RE_A_F_Reg), .RE_B_F_Reg(RE_B_F_Reg),
    .Robj_Reg_Exe(Robj_Reg_Exe), .mem_RE_Reg_Exe(mem_RE_Reg_Exe),
    .branch_taken_Exe(branch_taken_Exe), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .bubble_E(bubble_E), .bubble_WB(bubble_WB), .flush_F(flush_F),
    .mem_timeout(mem_timeout), .state_o(state_o)
`ifdef HAZARD_PERF_CNT_EN
    , .load_stall_cnt(load_stall_cnt), .flush_cnt_total(flush_cnt_total), .mem_wait_cnt(mem_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  wire [6:0] strobe_vec = {stall_F, stall_D, stall_E, stall_M, bubble_E, bubble_WB, flush_F};

  int checks = 0;
  int errors = 0;

  // Model: flush cycles still owed, an access in progress, and a flush deferred behind it.
  int m_flush_left, m_waited, m_deferred;
  bit m_in_wait, m_timeout;
  int m_load_cnt, m_flush_cnt, m_wait_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0; m_waited = 0; m_deferred = 0;
    m_in_wait = 0; m_timeout = 0;
    m_load_cnt = 0; m_flush_cnt = 0; m_wait_cnt = 0;
  endtask

  task automatic drive(input logic [3:0] a, b, obj, input logic rea, reb, ld, bt, req, rdy);
    Ra_F_Reg = a; Rb_F_Reg = b; Robj_Reg_Exe = obj;
    RE_A_F_Reg = rea; RE_B_F_Reg = reb; mem_RE_Reg_Exe = ld;
    branch_taken_Exe = bt; mem_req = req; mem_ready = rdy;
  endtask

  task automatic check_counters(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_load_cnt"},  32'(load_stall_cnt),  32'(m_load_cnt));
    check({tag, "_flush_cnt"}, 32'(flush_cnt_total), 32'(m_flush_cnt));
    check({tag, "_wait_cnt"},  32'(mem_wait_cnt),    32'(m_wait_cnt));
`else
    if (tag.len() == 0) $display("untagged counter check");
`endif
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step(input logic [3:0] a, b, obj, input logic rea, reb, ld, bt, req, rdy);
    logic miss, lu;
    logic [6:0] e;
    int es;
    drive(a, b, obj, rea, reb, ld, bt, req, rdy);
    @(negedge clk);
    miss = req && !rdy;
    lu   = ld && ((a == obj && rea) || (b == obj && reb));
    es   = m_in_wait ? 2 : (m_flush_left > 0 ? 1 : 0);
    check("state", 32'(state_o), 32'(es));
    check("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
    check_counters("cyc");
    e = '0;
    if (m_in_wait) begin
      if (miss && m_waited < MT) begin
        e = E_STALL_WB; m_waited++;
      end else begin
        if (miss) m_timeout = 1;
        m_in_wait = 0; m_flush_left = m_deferred; m_deferred = 0;
      end
    end else if (m_flush_left > 0) begin
      if (miss) begin
        e = E_STALL; m_in_wait = 1; m_waited = 1; m_deferred = m_flush_left; m_flush_left = 0;
      end else begin
        e = E_FLUSH; m_flush_left--;
      end
    end else if (miss) begin
      e = E_STALL_WB; m_in_wait = 1; m_waited = 1; m_deferred = bt ? FC : 0;
    end else if (bt) begin
      e = E_BRANCH; m_flush_left = FC - 1;
    end else if (lu) begin
      e = E_LOADUSE;
    end
    check("strobes", 32'(strobe_vec), 32'(e));
    if (e == E_LOADUSE) m_load_cnt++;
    if (e[0]) m_flush_cnt++;
    if (e[3]) m_wait_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset between clock edges with the current inputs left active.
  task automatic reset_mid(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_strobes"}, 32'(strobe_vec), 32'd0);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_timeout"}, 32'(mem_timeout), 32'd0);
    model_reset();
    check_counters(tag);
    @(negedge clk);
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    drive(4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_strobes", 32'(strobe_vec), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    check_counters("rst");
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Load-use on Ra, then same registers with the read enable off.
    step(4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd3, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd1, 4'd7, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Taken branch, then a branch pulse ignored while flushing.
    step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(4'd2, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Three miss cycles then ready.
    repeat (3) step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Ready never comes: forced release after MT stall cycles, sticky flag.
    repeat (MT + 1) step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Miss together with a branch: wait first, flush afterwards.
    step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);

    // Ready pulse outside a wait has no effect.
    step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-MEM_WAIT (clears the sticky timeout too), then mid-FLUSH.
    repeat (2) step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset_mid("rst_wait");
    idle(1);
    step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset_mid("rst_flush");
    idle(1);

    // Random traffic; every fourth block holds ready low to reach timeouts.
    for (int blk = 0; blk < 40; blk++) begin
      int req_pct, rdy_pct;
      req_pct = (blk % 4 == 1) ? 90 : 30;
      rdy_pct = (blk % 4 == 1) ? 0 : 50;
      for (int i = 0; i < 40; i++)
        step(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < req_pct),
             1'($urandom_range(0, 99) < rdy_pct));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
